// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Package : quad_pkg
// Purpose : Shared quadrature FSM states, {A,B} phase encodings and index type.
// Rev     : 1.0
// ============================================================================
package quad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PH_LEAD  = 3'd1,
        PH_BOTH  = 3'd2,
        PH_TRAIL = 3'd3,
        PH_ZERO  = 3'd4
    } state_t;

    localparam logic [1:0] c_PH_ZERO = 2'b00;
    localparam logic [1:0] c_PH_A    = 2'b10;
    localparam logic [1:0] c_PH_B    = 2'b01;
    localparam logic [1:0] c_PH_AB   = 2'b11;

    localparam int c_INDEX_CNT_W = 16;
    typedef logic [c_INDEX_CNT_W-1:0] index_cnt_t;

    // {A,B} shown while in a given state; CW leads with A, CCW leads with B.
    function automatic logic [1:0] phase_code(input state_t st, input logic cw);
        logic [1:0] code;
        code = c_PH_ZERO;
        case (st)
            PH_LEAD:  code = cw ? c_PH_A : c_PH_B;
            PH_BOTH:  code = c_PH_AB;
            PH_TRAIL: code = cw ? c_PH_B : c_PH_A;
            default:  code = c_PH_ZERO;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module  : quad_dwell_timer
// Purpose : Reloadable phase dwell counter; o_expire marks the final dwell cycle.
// Rev     : 1.0
// ============================================================================
module quad_dwell_timer #(
    parameter int TICKS = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_expire
);

    localparam int c_CNT_W = $clog2(TICKS + 1);

    logic [c_CNT_W-1:0] r_count;

    // Loading on the entry edge makes the state last exactly TICKS cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_CNT_W'(TICKS);
        end else if (r_count != '0) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    assign o_expire = (r_count == c_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/quad_phase_gen.sv
`default_nettype none
// ============================================================================
// Module  : quad_phase_gen
// Purpose : Quadrature A/B detent generator; index pulse output is compiled in
//           with macro QUAD_PHASE_GEN_INDEX_EN.
// Rev     : 1.0
// ============================================================================
module quad_phase_gen
    import quad_pkg::*;
#(
    parameter int PHASE_TICKS   = 4,
    parameter int STEPS_W       = 8,
    parameter int INDEX_DETENTS = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_cw,
    input  logic [STEPS_W-1:0] i_cmd_steps,
    output logic               o_phase_a,
    output logic               o_phase_b,
    output logic               o_done
`ifdef QUAD_PHASE_GEN_INDEX_EN
    ,
    output logic               o_index
`endif
);

    if (PHASE_TICKS < 1 || PHASE_TICKS > 65535 || STEPS_W < 1 ||
        INDEX_DETENTS < 1 || INDEX_DETENTS > 65536) begin : g_param_check
        $error("quad_phase_gen: parameter out of range");
    end

    state_t             r_state;
    logic [1:0]         r_phase;
    logic               r_cw;
    logic [STEPS_W-1:0] r_steps;
    logic               r_done;

    logic w_expire;
    logic w_last;
    logic w_load;

    assign w_last = (r_steps == STEPS_W'(1));

    // Reload on every entry into a phase state, never on the final return to IDLE.
    assign w_load = ((r_state == IDLE) && i_cmd_valid && (i_cmd_steps != '0)) ||
                    ((r_state != IDLE) && w_expire &&
                     !((r_state == PH_ZERO) && w_last));

    quad_dwell_timer #(
        .TICKS (PHASE_TICKS)
    ) u_dwell (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_phase <= c_PH_ZERO;
            r_cw    <= 1'b0;
            r_steps <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_cw    <= i_cmd_cw;
                        r_steps <= i_cmd_steps;
                        if (i_cmd_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= PH_LEAD;
                            r_phase <= phase_code(PH_LEAD, i_cmd_cw);
                        end
                    end
                end
                PH_LEAD: begin
                    if (w_expire) begin
                        r_state <= PH_BOTH;
                        r_phase <= phase_code(PH_BOTH, r_cw);
                    end
                end
                PH_BOTH: begin
                    if (w_expire) begin
                        r_state <= PH_TRAIL;
                        r_phase <= phase_code(PH_TRAIL, r_cw);
                    end
                end
                PH_TRAIL: begin
                    if (w_expire) begin
                        r_state <= PH_ZERO;
                        r_phase <= c_PH_ZERO;
                    end
                end
                PH_ZERO: begin
                    if (w_expire) begin
                        r_steps <= r_steps - STEPS_W'(1);
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PH_LEAD;
                            r_phase <= phase_code(PH_LEAD, r_cw);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_phase <= c_PH_ZERO;
                end
            endcase
        end
    end

    assign o_cmd_ready = (r_state == IDLE);
    assign o_phase_a   = r_phase[1];
    assign o_phase_b   = r_phase[0];
    assign o_done      = r_done;

`ifdef QUAD_PHASE_GEN_INDEX_EN
    index_cnt_t r_idx_cnt;
    index_cnt_t w_idx_nxt;
    logic       r_index;

    assign w_idx_nxt = (r_idx_cnt == index_cnt_t'(INDEX_DETENTS - 1)) ?
                       '0 : r_idx_cnt + index_cnt_t'(1);

    // The detent is counted as it enters its zero dwell, so the pulse spans that dwell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx_cnt <= '0;
            r_index   <= 1'b0;
        end else if ((r_state == PH_TRAIL) && w_expire) begin
            r_idx_cnt <= w_idx_nxt;
            r_index   <= (w_idx_nxt == '0);
        end else if ((r_state == PH_ZERO) && w_expire) begin
            r_index   <= 1'b0;
        end
    end

    assign o_index = r_index;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_phase_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad_phase_gen
// Purpose : Self-checking bench for quad_phase_gen (PHASE_TICKS=4, INDEX_DETENTS=4).
// Rev     : 1.0
// ============================================================================
module tb_quad_phase_gen;

    localparam int T     = 4;
    localparam int IDX_N = 4;

    logic       i_clk       = 1'b0;
    logic       i_rst_n     = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       i_cmd_cw    = 1'b0;
    logic [7:0] i_cmd_steps = 8'd0;
    logic       o_cmd_ready;
    logic       o_phase_a;
    logic       o_phase_b;
    logic       o_done;
`ifdef QUAD_PHASE_GEN_INDEX_EN
    logic       o_index;
`endif

    always #5 i_clk = ~i_clk;

    quad_phase_gen #(
        .PHASE_TICKS   (T),
        .STEPS_W       (8),
        .INDEX_DETENTS (IDX_N)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_cw    (i_cmd_cw),
        .i_cmd_steps (i_cmd_steps),
        .o_phase_a   (o_phase_a),
        .o_phase_b   (o_phase_b),
        .o_done      (o_done)
`ifdef QUAD_PHASE_GEN_INDEX_EN
        ,
        .o_index     (o_index)
`endif
    );

    typedef struct packed {
        logic [1:0] ab;
        logic       done;
        logic       ready;
        logic       idx;
    } exp_t;

    typedef struct {
        logic       cw;
        logic [7:0] steps;
        int         done_cyc;
        int         n_cw;
        int         n_ccw;
    } vec_t;

    exp_t       sb[$];
    int         checks    = 0;
    int         failures  = 0;
    int         model_idx = 0;
    int         dec_cw    = 0;
    int         dec_ccw   = 0;
    int         idx_hi    = 0;
    logic [1:0] prev_ab   = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs for one accepted command, starting the cycle after acceptance.
    task automatic push_cmd(input logic cw, input logic [7:0] steps);
        logic [1:0] seq [4];
        exp_t       e;
        if (cw) begin
            seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        end
        for (int d = 0; d < int'(steps); d++) begin
            for (int p = 0; p < 4; p++) begin
                if (p == 3) model_idx = (model_idx + 1) % IDX_N;
                for (int t = 0; t < T; t++) begin
                    e.ab    = seq[p];
                    e.done  = 1'b0;
                    e.ready = 1'b0;
                    e.idx   = (p == 3) && (model_idx == 0);
                    sb.push_back(e);
                end
            end
        end
        e.ab    = 2'b00;
        e.done  = 1'b1;
        e.ready = 1'b1;
        e.idx   = 1'b0;
        sb.push_back(e);
    endtask

    // Issues a command while the DUT is idle and returns the cycle (after acceptance) of o_done.
    task automatic do_cmd(input logic cw, input logic [7:0] steps, input bit keep_valid,
                          output int done_cyc);
        i_cmd_valid = 1'b1;
        i_cmd_cw    = cw;
        i_cmd_steps = steps;
        @(posedge i_clk);
        push_cmd(cw, steps);
        done_cyc = -1;
        for (int k = 1; k <= 4200; k++) begin
            #1;
            if (keep_valid) begin
                i_cmd_cw    = 1'($urandom_range(1));
                i_cmd_steps = 8'($urandom_range(255));
            end else begin
                i_cmd_valid = 1'b0;
            end
            if (o_done) begin
                done_cyc = k;
                break;
            end
            @(posedge i_clk);
        end
    endtask

    initial begin : monitor
        logic [1:0] cur;
        exp_t       e;
        forever begin
            @(posedge i_clk);
            #1;
            cur = {o_phase_a, o_phase_b};
            if (!i_rst_n) begin
                prev_ab = 2'b00;
            end else begin
                chk("gray_step", ($countones(cur ^ prev_ab) <= 1) ? 1 : 0, 1);
                if (prev_ab == 2'b01 && cur == 2'b00) dec_cw++;
                if (prev_ab == 2'b10 && cur == 2'b00) dec_ccw++;
`ifdef QUAD_PHASE_GEN_INDEX_EN
                if (o_index) idx_hi++;
`endif
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_phase", int'(cur), int'(e.ab));
                    chk("sb_done", int'(o_done), int'(e.done));
                    chk("sb_ready", int'(o_cmd_ready), int'(e.ready));
`ifdef QUAD_PHASE_GEN_INDEX_EN
                    chk("sb_index", int'(o_index), int'(e.idx));
`endif
                end else begin
                    chk("idle_done", int'(o_done), 0);
                end
                prev_ab = cur;
            end
        end
    end

    initial begin : main
        vec_t vecs [5];
        int   dc;
        int   b_cw;
        int   b_ccw;

        vecs[0] = '{cw: 1'b1, steps: 8'd3, done_cyc: 49, n_cw: 3, n_ccw: 0};
        vecs[1] = '{cw: 1'b0, steps: 8'd1, done_cyc: 17, n_cw: 0, n_ccw: 1};
        vecs[2] = '{cw: 1'b1, steps: 8'd0, done_cyc: 1,  n_cw: 0, n_ccw: 0};
        vecs[3] = '{cw: 1'b0, steps: 8'd2, done_cyc: 33, n_cw: 0, n_ccw: 2};
        vecs[4] = '{cw: 1'b1, steps: 8'd1, done_cyc: 17, n_cw: 1, n_ccw: 0};

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_phase", int'({o_phase_a, o_phase_b}), 0);
        chk("rst_done", int'(o_done), 0);
`ifdef QUAD_PHASE_GEN_INDEX_EN
        chk("rst_index", int'(o_index), 0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_after_rst", int'(o_cmd_ready), 1);

        for (int i = 0; i < 5; i++) begin
            b_cw  = dec_cw;
            b_ccw = dec_ccw;
            do_cmd(vecs[i].cw, vecs[i].steps, 1'b0, dc);
            chk("done_cycle", dc, vecs[i].done_cyc);
            chk("dec_cw_count", dec_cw - b_cw, vecs[i].n_cw);
            chk("dec_ccw_count", dec_ccw - b_ccw, vecs[i].n_ccw);
        end

        // Valid held high with changing values while busy; next command lands on the done cycle.
        do_cmd(1'b1, 8'd2, 1'b1, dc);
        chk("busy_hold_done", dc, 33);
        do_cmd(1'b0, 8'd1, 1'b0, dc);
        chk("after_hold_done", dc, 17);

        // Reset asserted in the middle of PH_BOTH.
        @(negedge i_clk);
        chk("sb_empty_pre_rst", sb.size(), 0);
        i_cmd_valid = 1'b1;
        i_cmd_cw    = 1'b1;
        i_cmd_steps = 8'd2;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        chk("abort_in_both", int'({o_phase_a, o_phase_b}), 3);
        #2;
        i_rst_n   = 1'b0;
        model_idx = 0;
        #1;
        chk("abort_phase", int'({o_phase_a, o_phase_b}), 0);
        chk("abort_done", int'(o_done), 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("abort_ready", int'(o_cmd_ready), 1);
        chk("abort_no_done", int'(o_done), 0);

        // Index spacing: 3 then 5 CW detents from a cleared counter.
        idx_hi = 0;
        do_cmd(1'b1, 8'd3, 1'b0, dc);
        chk("idx_cmd1_done", dc, 49);
        do_cmd(1'b1, 8'd5, 1'b0, dc);
        chk("idx_cmd2_done", dc, 81);
`ifdef QUAD_PHASE_GEN_INDEX_EN
        chk("idx_high_cycles", idx_hi, 2 * T);
`endif

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge i_clk);
        @(posedge i_clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        chk("final_ready", int'(o_cmd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
